// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
// The BNE state exists only when MIPS_CTRL_BNE_EN is defined.
package mips_pkg;

    localparam int CTRL_STATE_W = 4;

    typedef enum logic [CTRL_STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
`ifdef MIPS_CTRL_BNE_EN
        S_JUMP    = 4'd11,
        S_BNE     = 4'd12
`else
        S_JUMP    = 4'd11
`endif
    } ctrl_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       pc_write;
        logic       branch;
        logic       branch_n;
    } ctrl_out_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Purely combinational Moore decoder: control state to datapath control word.
// Adds the BNE decode when MIPS_CTRL_BNE_EN is defined.
module mips_ctrl_outdec
    import mips_pkg::*;
(
    input  ctrl_state_t state_i,
    output ctrl_out_t   ctrl_o
);

    always_comb begin
        // NOTE: default the whole word first so no path through the case can infer a latch.
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
                ctrl_o.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: ctrl_o.iord = 1'b1;
            S_MEMWB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.pc_src    = PCSRC_ALUOUT;
                ctrl_o.branch    = 1'b1;
            end
`ifdef MIPS_CTRL_BNE_EN
            S_BNE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.pc_src    = PCSRC_ALUOUT;
                ctrl_o.branch_n  = 1'b1;
            end
`endif
            S_ADDIWB: ctrl_o.reg_write = 1'b1;
            S_JUMP: begin
                ctrl_o.pc_src   = PCSRC_JUMP;
                ctrl_o.pc_write = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: state register, next-state
// logic, pc_en gating and reset forcing. Optional BNE support: MIPS_CTRL_BNE_EN.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               zero,
    output logic [1:0]         Alu_op,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               pc_en,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    ctrl_state_t state_q, state_d;
    ctrl_out_t   dec_out, ctrl;
    logic        illegal_op;
    logic        take_branch;

    always_comb begin
        state_d    = S_FETCH;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BNE;
`endif
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            // Write-back, branch and jump states, plus any unreachable encoding.
            default:   state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment; combinational blocks above use blocking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    mips_ctrl_outdec u_outdec (
        .state_i (state_q),
        .ctrl_o  (dec_out)
    );

    // Reset silences every control line combinationally, so no write escapes in the reset cycle.
    assign ctrl = reset ? '0 : dec_out;

`ifdef MIPS_CTRL_BNE_EN
    assign take_branch = (ctrl.branch & zero) | (ctrl.branch_n & ~zero);
`else
    assign take_branch = ctrl.branch & zero;
`endif

    assign pc_en      = ctrl.pc_write | take_branch;
    assign illegal    = illegal_op & ~reset;
    assign Alu_op     = ctrl.alu_op;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign iord       = ctrl.iord;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign state_o    = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl; covers both builds
// of MIPS_CTRL_BNE_EN.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic [1:0] Alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_en;
    logic       illegal;
    logic [3:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;

    mips_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .Alu_op     (Alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .pc_en      (pc_en),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 6'b000000; zero = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({mem_write, ir_write, reg_write, pc_en, illegal} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b want 00000", {mem_write, ir_write, reg_write, pc_en, illegal});
        end
        n_cmp++;
        if (state_o !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
        reset = 1'b0; #1;
        tick(); tick();
        n_cmp++;
        if (state_o !== 4'd6) begin n_bad++; $display("FAIL pre_reset_exec: got %0d want 6", state_o); end
        reset = 1'b1; #1;
        n_cmp++;
        if ({reg_write, Alu_op, alu_src_a} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_in_exec: got %b want 0000", {reg_write, Alu_op, alu_src_a});
        end
        tick();
        n_cmp++;
        if ({state_o, reg_write, ir_write, pc_en} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_cycle1: got %b want 0000000", {state_o, reg_write, ir_write, pc_en});
        end
        tick();
        n_cmp++;
        if ({state_o, reg_write} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_cycle2: got %b want 00000", {state_o, reg_write});
        end
        reset = 1'b0; #1;
        n_cmp++;
        if ({state_o, ir_write, pc_en, alu_src_b} !== {4'd0, 1'b1, 1'b1, 2'b01}) begin
            n_bad++;
            $display("FAIL post_reset_fetch: got %b want 0000_1_1_01", {state_o, ir_write, pc_en, alu_src_b});
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        opcode = 6'b100011; zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if (state_o !== exp_st[i]) begin n_bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_o, exp_st[i]); end
            n_cmp++;
            if ({reg_write, mem_to_reg, iord, mem_write} !== {exp_st[i] == 4'd4, exp_st[i] == 4'd4, exp_st[i] == 4'd3, 1'b0}) begin
                n_bad++;
                $display("FAIL lw_ctrl[%0d]: got %b in state %0d", i, {reg_write, mem_to_reg, iord, mem_write}, exp_st[i]);
            end
        end
        n_cmp++;
        if ({alu_src_b, illegal} !== 3'b010) begin n_bad++; $display("FAIL lw_back_fetch: got %b want 010", {alu_src_b, illegal}); end
    endtask

    task automatic test_rtype();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        opcode = 6'b000000; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if (state_o !== exp_st[i]) begin n_bad++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state_o, exp_st[i]); end
        end
        tick(); tick();
        n_cmp++;
        if ({Alu_op, alu_src_a, alu_src_b, reg_write} !== {2'b10, 1'b1, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL rtype_exec: got %b want 10_1_00_0", {Alu_op, alu_src_a, alu_src_b, reg_write});
        end
        tick();
        n_cmp++;
        if ({reg_dst, reg_write, mem_to_reg} !== 3'b110) begin
            n_bad++;
            $display("FAIL rtype_wb: got %b want 110", {reg_dst, reg_write, mem_to_reg});
        end
        tick();
    endtask

    task automatic test_sw();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        opcode = 6'b101011; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if ({state_o, mem_write, reg_write} !== {exp_st[i], exp_st[i] == 4'd5, 1'b0}) begin
                n_bad++;
                $display("FAIL sw_step[%0d]: got st=%0d mw=%b rw=%b want st=%0d", i, state_o, mem_write, reg_write, exp_st[i]);
            end
        end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            opcode = 6'b000100; zero = z[0];
            tick();
            n_cmp++;
            if ({state_o, pc_en} !== {4'd1, 1'b0}) begin
                n_bad++;
                $display("FAIL beq_decode z=%0d: got st=%0d pc_en=%b want st=1 pc_en=0", z, state_o, pc_en);
            end
            tick();
            n_cmp++;
            if ({state_o, pc_en, pc_src, Alu_op} !== {4'd8, z[0], 2'b01, 2'b01}) begin
                n_bad++;
                $display("FAIL beq_branch z=%0d: got %b want %b", z, {state_o, pc_en, pc_src, Alu_op}, {4'd8, z[0], 2'b01, 2'b01});
            end
            tick();
            n_cmp++;
            if (state_o !== 4'd0) begin n_bad++; $display("FAIL beq_return z=%0d: got %0d want 0", z, state_o); end
        end
    endtask

    task automatic test_addi_jump();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
        opcode = 6'b001000; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if ({state_o, reg_write, reg_dst, mem_to_reg} !== {exp_st[i], exp_st[i] == 4'd10, 2'b00}) begin
                n_bad++;
                $display("FAIL addi_step[%0d]: got st=%0d rw=%b want st=%0d", i, state_o, reg_write, exp_st[i]);
            end
        end
        opcode = 6'b000010;
        tick(); tick();
        n_cmp++;
        if ({state_o, pc_en, pc_src} !== {4'd11, 1'b1, 2'b10}) begin
            n_bad++;
            $display("FAIL jump: got %b want 1011_1_10", {state_o, pc_en, pc_src});
        end
        tick();
        n_cmp++;
        if (state_o !== 4'd0) begin n_bad++; $display("FAIL jump_return: got %0d want 0", state_o); end
    endtask

    task automatic test_illegal();
        opcode = 6'b111111; zero = 1'b0;
        #1;
        n_cmp++;
        if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_in_fetch: got %b want 0", illegal); end
        tick();
        n_cmp++;
        if ({state_o, illegal, mem_write, reg_write} !== {4'd1, 1'b1, 2'b00}) begin
            n_bad++;
            $display("FAIL illegal_decode: got %b want 0001_1_00", {state_o, illegal, mem_write, reg_write});
        end
        tick();
        n_cmp++;
        if ({state_o, illegal, ir_write} !== {4'd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL illegal_after: got %b want 0000_0_1", {state_o, illegal, ir_write});
        end
    endtask

    task automatic test_bne();
        opcode = 6'b000101; zero = 1'b0;
        tick();
`ifdef MIPS_CTRL_BNE_EN
        n_cmp++;
        if (illegal !== 1'b0) begin n_bad++; $display("FAIL bne_decode_illegal: got %b want 0", illegal); end
        tick();
        n_cmp++;
        if ({state_o, pc_en, pc_src, Alu_op} !== {4'd12, 1'b1, 2'b01, 2'b01}) begin
            n_bad++;
            $display("FAIL bne_taken: got %b want 1100_1_01_01", {state_o, pc_en, pc_src, Alu_op});
        end
        zero = 1'b1; #1;
        n_cmp++;
        if (pc_en !== 1'b0) begin n_bad++; $display("FAIL bne_not_taken: got %b want 0", pc_en); end
        tick();
`else
        n_cmp++;
        if ({state_o, illegal} !== {4'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL bne_disabled_illegal: got %b want 0001_1", {state_o, illegal});
        end
        tick();
`endif
        n_cmp++;
        if (state_o !== 4'd0) begin n_bad++; $display("FAIL bne_return: got %0d want 0", state_o); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_sw();
        test_beq();
        test_addi_jump();
        test_illegal();
        test_bne();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
